// File: rtl/fpu_pkg.sv
// Shared FPU issue definitions: op codes, rounding modes, fflags bit positions
// and the issue-controller state encoding.
package fpu_pkg;

    localparam logic [4:0] OP_FADD       = 5'b00000;
    localparam logic [4:0] OP_FSUB       = 5'b00001;
    localparam logic [4:0] OP_FMUL       = 5'b00010;
    localparam logic [4:0] OP_FDIV       = 5'b00011;
    localparam logic [4:0] OP_FSGNJ      = 5'b00100;
    localparam logic [4:0] OP_FMINMAX    = 5'b00101;
    localparam logic [4:0] OP_FSQRT      = 5'b01011;
    localparam logic [4:0] OP_FCMP       = 5'b10100;
    localparam logic [4:0] OP_FCVT_W_S   = 5'b11000;
    localparam logic [4:0] OP_FCVT_S_W   = 5'b11010;
    localparam logic [4:0] OP_FCLASS_FMV = 5'b11100;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;
    localparam logic [2:0] RM_DYN = 3'b111;

    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } issue_state_t;

    // Ops whose rm field is a real rounding mode rather than a funct3 selector.
    function automatic logic op_is_arith(input logic [4:0] op);
        case (op)
            OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV,
            OP_FSQRT, OP_FCVT_W_S, OP_FCVT_S_W: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fpu_rm_resolve.sv
// Resolves the dynamic rounding mode against frm and flags reserved encodings
// for arithmetic ops; non-arithmetic ops pass their funct3 through untouched.
module fpu_rm_resolve
    import fpu_pkg::*;
(
    input  logic [4:0] op,
    input  logic [2:0] rm,
    input  logic [2:0] frm,
    output logic [2:0] rm_out,
    output logic       is_arith,
    output logic       illegal
);

    always_comb begin
        is_arith = op_is_arith(op);
        rm_out   = (is_arith && (rm == RM_DYN)) ? frm : rm;
        // 101..111 are reserved once resolved, including frm itself holding DYN.
        illegal  = is_arith && (rm_out > RM_RMM);
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue-side FPU controller: accepts one instruction, holds start/op to the FPU
// until done, then returns result and fflags; handles flush and a watchdog.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [2:0]  req_rm,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic        req_rs2_lsb,
    input  logic [4:0]  req_rd,
    input  logic        req_int_dest,
    input  logic [2:0]  frm,
    output logic        fpu_start,
    output logic [4:0]  fpu_op,
    output logic [2:0]  fpu_rm,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic        fpu_rs2_lsb,
    input  logic [31:0] fpu_result,
    input  logic        fpu_done,
    input  logic        fpu_invalid,
    input  logic        fpu_div_by_zero,
    input  logic        fpu_overflow,
    input  logic        fpu_underflow,
    input  logic        fpu_inexact,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_int_dest,
    output logic        fflags_we,
    output logic [4:0]  fflags_set,
    output logic        illegal_rm,
    output logic        timeout,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    issue_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load, capture, illegal_d, timeout_d;
    logic [4:0]    op_q, rd_q, flags_q;
    logic [2:0]    rm_q;
    logic [31:0]   a_q, b_q, result_q;
    logic          lsb_q, int_dest_q, illegal_q, timeout_q;
    logic [2:0]    res_rm;
    logic          res_illegal, unused_is_arith;

    fpu_rm_resolve u_rm_resolve (
        .op       (req_op),
        .rm       (req_rm),
        .frm      (frm),
        .rm_out   (res_rm),
        .is_arith (unused_is_arith),
        .illegal  (res_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        capture   = 1'b0;
        illegal_d = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    load = 1'b1;
                    if (res_illegal) begin
                        illegal_d = 1'b1;
                    end else begin
                        state_d = S_EXEC;
                        cnt_d   = '0;
                    end
                end
            end
            S_EXEC: begin
                // Flush outranks a same-cycle done; done outranks the watchdog.
                if (flush) begin
                    state_d = S_IDLE;
                end else if (fpu_done) begin
                    capture = 1'b1;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            op_q       <= '0;
            rm_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            lsb_q      <= 1'b0;
            rd_q       <= '0;
            int_dest_q <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            if (load) begin
                op_q       <= req_op;
                rm_q       <= res_rm;
                a_q        <= req_rs1;
                b_q        <= req_rs2;
                lsb_q      <= req_rs2_lsb;
                rd_q       <= req_rd;
                int_dest_q <= req_int_dest;
            end
            if (capture) begin
                result_q       <= fpu_result;
                flags_q[FF_NV] <= fpu_invalid;
                flags_q[FF_DZ] <= fpu_div_by_zero;
                flags_q[FF_OF] <= fpu_overflow;
                flags_q[FF_UF] <= fpu_underflow;
                flags_q[FF_NX] <= fpu_inexact;
            end
        end
    end

    // Handshakes: a request transfers on a clock edge where req_valid and
    // req_ready are both 1; the FPU sees fpu_start held high with stable
    // operands until it raises fpu_done, and wb_valid is a one-cycle strobe.
    assign req_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign state_dbg   = state_q;
    assign fpu_start   = (state_q == S_EXEC);
    assign fpu_op      = op_q;
    assign fpu_rm      = rm_q;
    assign fpu_a       = a_q;
    assign fpu_b       = b_q;
    assign fpu_rs2_lsb = lsb_q;
    assign wb_valid    = (state_q == S_RESP) && !flush;
    assign fflags_we   = wb_valid;
    assign wb_data     = result_q;
    assign wb_rd       = rd_q;
    assign wb_int_dest = int_dest_q;
    assign fflags_set  = flags_q;
    assign illegal_rm  = illegal_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: directed scenarios plus randomized
// transactions checked cycle by cycle against a transaction-level model.
module tb_fpu_issue_ctrl;
    import fpu_pkg::*;

    // Watchdog long enough for the 10-cycle divide scenario.
    localparam int TO = 12;
    localparam int WIN = 16;

    logic        clk = 1'b0, reset = 1'b0, flush = 1'b0, req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_op = '0, req_rd = '0;
    logic [2:0]  req_rm = '0, frm = '0;
    logic [31:0] req_rs1 = '0, req_rs2 = '0;
    logic        req_rs2_lsb = 1'b0, req_int_dest = 1'b0;
    logic        fpu_start, fpu_rs2_lsb, fpu_done;
    logic [4:0]  fpu_op;
    logic [2:0]  fpu_rm;
    logic [31:0] fpu_a, fpu_b, fpu_result;
    logic        fpu_invalid, fpu_div_by_zero, fpu_overflow, fpu_underflow, fpu_inexact;
    logic        wb_valid, wb_int_dest, fflags_we, illegal_rm, timeout, busy;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd, fflags_set;
    logic [1:0]  state_dbg;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fpu_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rm(req_rm), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_rs2_lsb(req_rs2_lsb), .req_rd(req_rd), .req_int_dest(req_int_dest),
        .frm(frm),
        .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_rm(fpu_rm),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_rs2_lsb(fpu_rs2_lsb),
        .fpu_result(fpu_result), .fpu_done(fpu_done),
        .fpu_invalid(fpu_invalid), .fpu_div_by_zero(fpu_div_by_zero),
        .fpu_overflow(fpu_overflow), .fpu_underflow(fpu_underflow),
        .fpu_inexact(fpu_inexact),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_int_dest(wb_int_dest), .fflags_we(fflags_we), .fflags_set(fflags_set),
        .illegal_rm(illegal_rm), .timeout(timeout), .busy(busy),
        .state_dbg(state_dbg)
    );

    // FPU model: done in the m_lat-th start cycle (1 = combinational, 0 = never).
    int          m_lat = 1;
    int          exec_cnt = 0;
    logic [31:0] m_res = '0;
    logic [4:0]  m_flags = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset)         exec_cnt <= 0;
        else if (fpu_start) exec_cnt <= exec_cnt + 1;
        else                exec_cnt <= 0;
    end

    assign fpu_done   = fpu_start && (m_lat != 0) && (exec_cnt == m_lat - 1);
    assign fpu_result = fpu_done ? m_res : ~m_res;
    assign {fpu_invalid, fpu_div_by_zero, fpu_overflow, fpu_underflow, fpu_inexact} =
        fpu_done ? m_flags : ~m_flags;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_fpu_ctl"}, 32'({fpu_start, fpu_op, fpu_rm, fpu_rs2_lsb}), 32'd0);
        check({tag, "_fpu_a"}, fpu_a, 32'd0);
        check({tag, "_fpu_b"}, fpu_b, 32'd0);
        check({tag, "_wb_ctl"}, 32'({wb_valid, wb_rd, wb_int_dest, fflags_we, fflags_set}), 32'd0);
        check({tag, "_wb_data"}, wb_data, 32'd0);
        check({tag, "_pulses"}, 32'({illegal_rm, timeout, busy, state_dbg}), 32'd0);
    endtask

    // Called just after a negedge with the block idle; issues one request and
    // checks every output for WIN cycles against the outcome the rules predict.
    task automatic run_op(input logic [4:0] op, input logic [2:0] rm, input logic [2:0] frm_v,
                          input logic [31:0] a, input logic [31:0] b, input logic lsb,
                          input logic [4:0] rd, input logic intd, input int lat,
                          input int flush_at, input logic [31:0] res, input logic [4:0] flags);
        bit          arith, ill;
        logic [2:0]  rrm;
        int          n_fl, n_dn, n_st, rdy_c, wb_c, to_c, seen;
        arith = op inside {OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV, OP_FSQRT, OP_FCVT_W_S, OP_FCVT_S_W};
        rrm   = (arith && rm == 3'b111) ? frm_v : rm;
        ill   = arith && (rrm inside {3'b101, 3'b110, 3'b111});
        n_fl  = (flush_at == 0) ? 1000 : flush_at;
        n_dn  = (lat == 0) ? 1000 : lat;
        wb_c  = -1;
        to_c  = -1;
        seen  = 0;
        if (ill) begin
            n_st = 0; rdy_c = 1;
        end else if (n_fl <= n_dn && n_fl <= TO) begin
            n_st = n_fl; rdy_c = n_fl + 1;
        end else if (n_dn <= TO) begin
            n_st = n_dn; wb_c = n_dn + 1; rdy_c = n_dn + 2;
            exp_q.push_back(res);
        end else begin
            n_st = TO; to_c = TO + 1; rdy_c = TO + 1;
        end

        check("pre_ready", 32'(req_ready), 32'd1);
        req_op = op; req_rm = rm; frm = frm_v; req_rs1 = a; req_rs2 = b;
        req_rs2_lsb = lsb; req_rd = rd; req_int_dest = intd;
        m_lat = lat; m_res = res; m_flags = flags;
        req_valid = 1'b1;
        flush = 1'b0;

        for (int c = 1; c <= WIN; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            flush = 1'b0;
            #1;
            check("req_ready", 32'(req_ready), 32'(c >= rdy_c));
            check("busy", 32'(busy), 32'(c < rdy_c));
            check("fpu_start", 32'(fpu_start), 32'(c <= n_st));
            if (c <= n_st) begin
                check("fpu_op", 32'(fpu_op), 32'(op));
                check("fpu_rm", 32'(fpu_rm), 32'(rrm));
                check("fpu_a", fpu_a, a);
                check("fpu_b", fpu_b, b);
                check("fpu_rs2_lsb", 32'(fpu_rs2_lsb), 32'(lsb));
            end
            check("wb_valid", 32'(wb_valid), 32'(c == wb_c));
            check("fflags_we", 32'(fflags_we), 32'(c == wb_c));
            if (c == wb_c && exp_q.size() > 0) begin
                check("wb_data", wb_data, exp_q.pop_front());
                check("fflags_set", 32'(fflags_set), 32'(flags));
                check("wb_rd", 32'(wb_rd), 32'(rd));
                check("wb_int_dest", 32'(wb_int_dest), 32'(intd));
            end
            check("illegal_rm", 32'(illegal_rm), 32'(ill && c == 1));
            check("timeout", 32'(timeout), 32'(c == to_c));
            if (fpu_start) begin
                seen++;
                if (seen == flush_at) flush = 1'b1;
            end
        end
        flush = 1'b0;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    logic [4:0] pool[11] = '{OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV, OP_FSGNJ, OP_FMINMAX,
                             OP_FSQRT, OP_FCMP, OP_FCVT_W_S, OP_FCVT_S_W, OP_FCLASS_FMV};

    initial begin
        // Power-on reset
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        reset = 1'b1;
        #1;

        // FADD, combinational done: start in cycle 1 only, wb in 2, ready in 3
        run_op(OP_FADD, RM_RNE, RM_RNE, 32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd5, 1'b0,
               1, 0, 32'h4040_0000, 5'b00000);
        // FDIV by zero with dynamic rm resolving to frm=RTZ, 10-cycle divide
        run_op(OP_FDIV, RM_DYN, RM_RTZ, 32'h3F80_0000, 32'h0000_0000, 1'b0, 5'd6, 1'b0,
               10, 0, 32'h7F80_0000, 5'b01000);
        // Reserved rm on an arithmetic op
        run_op(OP_FMUL, 3'b101, RM_RNE, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 5'd7, 1'b0,
               1, 0, 32'h0, 5'b0);
        // Dynamic rm with frm itself reserved
        run_op(OP_FADD, RM_DYN, 3'b110, 32'h1, 32'h2, 1'b0, 5'd8, 1'b0, 1, 0, 32'h0, 5'b0);
        // FCMP: rm is funct3 and passes through
        run_op(OP_FCMP, RM_RDN, RM_RNE, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 5'd9, 1'b1,
               1, 0, 32'h0000_0001, 5'b00000);
        // FCMP with funct3=111 must not pick up frm nor be rejected
        run_op(OP_FCMP, 3'b111, RM_RUP, 32'h5, 32'h6, 1'b1, 5'd10, 1'b1,
               2, 0, 32'h0000_0000, 5'b10000);
        // FSQRT flushed in its third EXEC cycle, then a normal FADD
        run_op(OP_FSQRT, RM_RNE, RM_RNE, 32'h4080_0000, 32'h0, 1'b0, 5'd11, 1'b0,
               0, 3, 32'h4000_0000, 5'b0);
        run_op(OP_FADD, RM_RNE, RM_RNE, 32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd12, 1'b0,
               1, 0, 32'h4040_0000, 5'b00001);
        // Flush in the same cycle as done wins
        run_op(OP_FMUL, RM_RTZ, RM_RNE, 32'h3, 32'h4, 1'b0, 5'd13, 1'b0, 2, 2, 32'hAAAA, 5'b0);
        // Watchdog: never done, and done landing exactly on the last allowed cycle
        run_op(OP_FDIV, RM_RNE, RM_RNE, 32'h3F80_0000, 32'h4040_0000, 1'b0, 5'd14, 1'b0,
               0, 0, 32'h0, 5'b0);
        run_op(OP_FDIV, RM_RMM, RM_RNE, 32'h3F80_0000, 32'h4040_0000, 1'b0, 5'd15, 1'b0,
               TO, 0, 32'h3EAA_AAAB, 5'b00001);
        run_op(OP_FDIV, RM_RNE, RM_RNE, 32'h3F80_0000, 32'h4040_0000, 1'b0, 5'd16, 1'b0,
               TO + 1, 0, 32'h0, 5'b0);

        // Request presented together with flush is ignored
        req_op = OP_FADD; req_rm = RM_RNE; m_lat = 1; req_valid = 1'b1; flush = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            flush = 1'b0;
            #1;
            check("flushreq_start", 32'(fpu_start), 32'd0);
            check("flushreq_busy", 32'(busy), 32'd0);
            check("flushreq_pulses", 32'({wb_valid, illegal_rm, timeout}), 32'd0);
        end

        // Reset asserted mid-EXEC clears everything without waiting for a clock
        req_op = OP_FDIV; req_rm = RM_RUP; req_rs1 = 32'hCAFE_F00D; req_rs2 = 32'h1;
        req_rd = 5'd20; req_int_dest = 1'b1; req_rs2_lsb = 1'b1; m_lat = 10;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        reset = 1'b1;
        #1;
        run_op(OP_FADD, RM_RNE, RM_RNE, 32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd21, 1'b0,
               1, 0, 32'h4040_0000, 5'b00000);

        // Randomized transactions
        for (int n = 0; n < 150; n++) begin
            logic [4:0] op;
            logic [2:0] rm;
            op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : pool[$urandom_range(0, 10)];
            rm = ($urandom_range(0, 3) == 0) ? RM_DYN : 3'($urandom_range(0, 7));
            run_op(op, rm, 3'($urandom_range(0, 7)), $urandom, $urandom,
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, TO + 2),
                   ($urandom_range(0, 4) == 0) ? $urandom_range(1, 5) : 0,
                   $urandom, 5'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Issue-side controller for the FPU arithmetic unit. It accepts one decoded floating-point instruction at a time from the core pipeline and resolves the dynamic rounding mode against `frm`. It then drives the FPU `start`/`op` interface, holding it until `done`, and returns the result plus the RISC-V `fflags` bits to writeback. It adds flush and watchdog-timeout handling.

## Interface
- `TIMEOUT_CYCLES`, 64: maximum number of EXEC cycles before the operation is aborted.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `flush` in 1: kills any in-flight operation.
- `req_valid` in 1, `req_ready` out 1: request handshake; transfer occurs when both are 1 at a clock edge.
- `req_op` in 5, `req_rm` in 3: FPU op code and the instruction's rm/funct3 field.
- `req_rs1`, `req_rs2` in 32: operand A and operand B.
- `req_rs2_lsb` in 1: signed/unsigned select for conversions.
- `req_rd` in 5, `req_int_dest` in 1: destination register; `req_int_dest`=1 selects the integer register file.
- `frm` in 3: current fcsr.frm value.
- `fpu_start` out 1, `fpu_op` out 5, `fpu_rm` out 3, `fpu_a` out 32, `fpu_b` out 32, `fpu_rs2_lsb` out 1: drive the FPU.
- `fpu_result` in 32, `fpu_done` in 1: FPU result and completion.
- `fpu_invalid`, `fpu_div_by_zero`, `fpu_overflow`, `fpu_underflow`, `fpu_inexact` in 1: FPU exception flags.
- `wb_valid` out 1, `wb_data` out 32, `wb_rd` out 5, `wb_int_dest` out 1: writeback.
- `fflags_we` out 1, `fflags_set` out 5: flags to be ORed into fcsr.fflags, ordered {NV,DZ,OF,UF,NX}.
- `illegal_rm` out 1, `timeout` out 1: single-cycle error pulses.
- `busy` out 1: the state is not IDLE.

## Operation
- States are IDLE, EXEC and RESP.
- **Arithmetic ops:**
  - The arithmetic set is 00000, 00001, 00010, 00011, 01011, 11000 and 11010.
  - For these ops, `req_rm`=111 resolves to `frm`; any other value passes through unchanged.
  - A resolved rm of 101, 110 or 111 is illegal.
  - For all other ops, `req_rm` is funct3 and is passed through unchecked.
- **IDLE:**
  - `req_ready`=1.
  - On accept with `flush`=0, register the op, resolved rm, operands, `rs2_lsb`, `rd` and `int_dest`.
  - If the rm is illegal, pulse `illegal_rm` in the next cycle, stay in IDLE and do not start the FPU.
  - Otherwise go to EXEC and clear the watchdog counter.
  - `req_valid` with `flush`=1 is ignored.
- **EXEC:**
  - `fpu_start`=1 continuously, and all `fpu_*` drive outputs are held stable.
  - If `flush`=1, go to IDLE with no writeback. Flush has priority over `fpu_done`.
  - Else if `fpu_done`=1, capture `fpu_result` and the five flags, then go to RESP.
  - Else if the counter equals `TIMEOUT_CYCLES`-1, pulse `timeout` in the next cycle and go to IDLE with no writeback.
  - Otherwise the counter increments.
- **RESP:**
  - `wb_valid` = `fflags_we` = !`flush` for exactly one cycle.
  - `fflags_set` = {invalid, div_by_zero, overflow, underflow, inexact} as captured.
  - `fpu_start`=0.
  - Always go to IDLE. This guarantees a `start`-low cycle between consecutive operations.
- **Counter:** width $clog2(`TIMEOUT_CYCLES`)+1; it saturates and never wraps.

## Timing
- **Reset:**
  - Asserting `reset` mid-operation immediately forces IDLE.
  - All outputs are 0 except `req_ready`=1.
  - All registered operand and result fields are cleared.
- **Single-cycle ops (FPU `done` combinational with `start`):**
  - Accept edge at cycle 0.
  - EXEC in cycle 1.
  - RESP (`wb_valid`) in cycle 2.
  - `req_ready` high again in cycle 3.
  - Throughput is one op per 3 cycles.
- **Multi-cycle ops (MUL/DIV/SQRT):** `wb_valid` is asserted the cycle after the first cycle in which `fpu_done`=1.
- **Registered outputs:** `illegal_rm` and `timeout` are registered and are never asserted together with `wb_valid`.
- **Write-enable timing:** `fflags_we` is asserted even when `fflags_set`=0; the fcsr treats it as an OR-accumulate.

## Structure
- **Package `fpu_pkg`:**
  - Op code constants: FADD, FSUB, FMUL, FDIV, FSQRT, FSGNJ, FMINMAX, FCVT_W_S, FCVT_S_W, FCMP, FCLASS/FMV.
  - Rounding mode constants: RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100, DYN=111.
  - fflags bit indices (NV=4, DZ=3, OF=2, UF=1, NX=0).
  - Issue state enum.
- **Sub-module `fpu_rm_resolve`** (combinational):
  - Inputs: op, rm, frm.
  - Outputs: resolved rm, is_arith, illegal.
  - It is instantiated once, on the accept path.

## Test plan
- **FADD:** FADD (00000) with rs1=0x3F800000, rs2=0x40000000, rm=000 and a combinational-done FPU model.
  - `fpu_start` is high for cycle 1 only.
  - `wb_data`=0x40400000, `fflags_set`=0 in cycle 2.
  - `req_ready`=1 in cycle 3.
- **FDIV by zero, dynamic rm:** FDIV with rs1=0x3F800000, rs2=0x00000000, rm=111, frm=001, and the FPU model asserting done after 10 cycles.
  - `fpu_rm`=001 and `fpu_start` is held for 10 cycles.
  - `wb_data`=0x7F800000, `fflags_set`=01000.
- **Illegal rm:** FMUL with rm=101.
  - `fpu_start` is never asserted, `illegal_rm` pulses once, and the block stays in IDLE.
- **rm passthrough:** FCMP (10100) with rm=010.
  - Accepted, `fpu_rm`=010, and no illegal pulse.
- **Flush:** FSQRT with `flush` asserted in the third EXEC cycle.
  - `fpu_start`=0 on the next cycle; `wb_valid` and `fflags_we` are never asserted.
  - A back-to-back FADD is then accepted normally.
- **Timeout:** `TIMEOUT_CYCLES`=8 with `fpu_done` held at 0.
  - `timeout` pulses after 8 EXEC cycles, the block returns to IDLE, and there is no writeback.
- **Reset mid-operation:** `reset` driven low mid-EXEC.
  - All outputs are 0 asynchronously except `req_ready`=1.
  - After release, an FADD completes with the nominal 3-cycle latency.
